// File: rtl/comparador_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding,
// flag bit positions and the flag-vector builder.
package comparador_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    localparam int unsigned FLAG_W  = 6;
    localparam int unsigned FLAG_GT = 5;
    localparam int unsigned FLAG_LE = 4;
    localparam int unsigned FLAG_EQ = 3;
    localparam int unsigned FLAG_NE = 2;
    localparam int unsigned FLAG_GE = 1;
    localparam int unsigned FLAG_LT = 0;

    // Expand a GT/LT decision into the full, mutually consistent flag set.
    function automatic logic [FLAG_W-1:0] make_flags(input logic gt, input logic lt);
        logic [FLAG_W-1:0] f;
        logic              eq;
        eq         = !gt && !lt;
        f          = '0;
        f[FLAG_GT] = gt;
        f[FLAG_LE] = !gt;
        f[FLAG_EQ] = eq;
        f[FLAG_NE] = !eq;
        f[FLAG_GE] = !lt;
        f[FLAG_LT] = lt;
        return f;
    endfunction

endpackage

// File: rtl/comparador_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module comparador_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    always_comb begin
        gt = (a > b);
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/comparador_serial.sv
// Serial magnitude comparator: walks the operands CHUNK bits per cycle from
// the MSB end and stops at the first differing chunk.
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic              busy,
    output logic              done,
    output logic [FLAG_W-1:0] S
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] sign_flip;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             gt;
    logic             lt;
    logic             eq;

    // Flipping the sign bits once at latch time makes unsigned chunk order match signed order.
    always_comb begin
        sign_flip = {signed_mode, (WIDTH-1)'(0)};
        a_chunk   = CHUNK'(a_q >> (CHUNK * 32'(idx)));
        b_chunk   = CHUNK'(b_q >> (CHUNK * 32'(idx)));
    end

    comparador_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .gt (gt),
        .lt (lt),
        .eq (eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A ^ sign_flip;
                        b_q   <= B ^ sign_flip;
                        idx   <= IW'(N - 1);
                        busy  <= 1'b1;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    // Decide on the first differing chunk, or on the last chunk if all match.
                    if (!eq || (idx == '0)) begin
                        S     <= make_flags(gt, lt);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_serial.sv
// Scoreboarded random and directed bench for comparador_serial
// (WIDTH=16, CHUNK=4).
module tb_comparador_serial;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CHUNK = 4;
    localparam int unsigned N     = WIDTH / CHUNK;

    logic             clk;
    logic             reset;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [5:0]       s;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [5:0] exp_q[$];
    int         due_q[$];

    comparador_serial #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (a),
        .B           (b),
        .busy        (busy),
        .done        (done),
        .S           (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: flags straight from integer comparison of the operands.
    function automatic logic [5:0] ref_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic sm);
        logic g, l, e;
        if (sm) begin
            g = $signed(x) > $signed(y);
            l = $signed(x) < $signed(y);
        end else begin
            g = x > y;
            l = x < y;
        end
        e = (x == y);
        return {g, !g, e, !e, !l, l};
    endfunction

    // Reference: 1-based position from the MSB of the first differing chunk, else N.
    function automatic int ref_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x ^ y;
        for (int i = 0; i < int'(N); i++) begin
            if (d[WIDTH-1-i*CHUNK -: CHUNK] != '0) return i + 1;
        end
        return int'(N);
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            logic [5:0] e;
            int         due;
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending compare (cycle %0d)", cyc);
            end else begin
                e   = exp_q.pop_front();
                due = due_q.pop_front();
                check("flags", 32'(s), 32'(e));
                check("latency_cycle", 32'(cyc), 32'(due));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'(0));
    endtask

    // Drive one request at a negedge; done is due exp_lat edges after the acceptance edge.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sm,
                         input logic [5:0] exp_s, input int exp_lat);
        wait_idle();
        a           = x;
        b           = y;
        signed_mode = sm;
        start       = 1'b1;
        exp_q.push_back(exp_s);
        due_q.push_back(cyc + 1 + exp_lat);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int d0;
        int n;
        logic [WIDTH-1:0] x, y, m;
        logic sm;

        reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_s", 32'(s), 32'(0));

        // Directed cases with hand-derived results
        issue(16'h1234, 16'h1234, 1'b0, 6'b011010, 4);
        issue(16'h8000, 16'h0001, 1'b1, 6'b010101, 1);
        issue(16'h8000, 16'h0001, 1'b0, 6'b100110, 1);
        issue(16'hFFFE, 16'hFFFF, 1'b1, 6'b010101, 4);
        issue(16'h1200, 16'h1300, 1'b0, 6'b010101, 2);
        issue(16'h1240, 16'h1230, 1'b1, 6'b100110, 3);

        // Reset mid-compare: no done afterwards, outputs cleared
        wait_idle();
        @(negedge clk);
        d0 = done_cnt;
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_s", 32'(s), 32'(0));
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(d0));

        // Start while busy is ignored; operand changes do not disturb the compare
        d0 = done_cnt;
        issue(16'h1234, 16'h1234, 1'b0, 6'b011010, 4);
        a = 16'hFFFF; b = 16'h0000; signed_mode = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        check("busy_start_ignored", 32'(done_cnt), 32'(d0 + 1));

        // Back-to-back: second start during the done cycle of the first
        issue(16'h1200, 16'h1300, 1'b0, 6'b010101, 2);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done", 32'(done), 32'(1));
        issue(16'h1240, 16'h1230, 1'b0, 6'b100110, 3);
        check("b2b_accepted", 32'(busy), 32'(1));
        n = 0;
        while (busy && n < 20) begin
            check("b2b_s_hold", 32'(s), 32'(6'b010101));
            @(negedge clk);
            n++;
        end

        // Random pairs in both modes; half are biased toward long common prefixes
        for (int i = 0; i < 10000; i++) begin
            x  = WIDTH'($urandom);
            sm = 1'($urandom);
            if ($urandom_range(1, 0) == 0) begin
                y = WIDTH'($urandom);
            end else begin
                m = WIDTH'((32'd1 << (CHUNK * $urandom_range(N, 0))) - 1);
                y = x ^ (WIDTH'($urandom) & m);
            end
            issue(x, y, sm, ref_flags(x, y, sm), ref_lat(x, y));
        end

        wait_idle();
        repeat (8) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparador_serial.md
COMPARADOR_SERIAL -- requirements
Module: comparador_serial

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Parameter WIDTH, default 16: operand width in bits.
REQ-003 Parameter CHUNK, default 4: bits compared per cycle. WIDTH SHALL be a multiple of CHUNK. N = WIDTH/CHUNK.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port start, input, 1: request a comparison; accepted only when busy=0.
REQ-007 Port signed_mode, input, 1: 1 = two's-complement compare; 0 = unsigned. Sampled with the operands.
REQ-008 Port A, input, WIDTH: first operand.
REQ-009 Port B, input, WIDTH: second operand.
REQ-010 Port busy, output, 1: a comparison is in progress.
REQ-011 Port done, output, 1: one-cycle pulse when S is updated.
REQ-012 Port S, output, 6: flags. S[5]=A>B, S[4]=A<=B, S[3]=A==B, S[2]=A!=B, S[1]=A>=B, S[0]=A<B.

Function
REQ-013 SHALL have two states. IDLE goes to COMPARE on start=1. COMPARE goes to IDLE on the decision edge.
REQ-014 Acceptance edge E0 (start=1, busy=0) SHALL latch A, B and signed_mode, set busy=1, and set chunk index to N-1 (MSB chunk).
REQ-015 At each edge Ek (k=1..N) in COMPARE, SHALL compare the current chunk of the latched operands unsigned, then decrement the index.
REQ-016 In signed mode, SHALL invert bit WIDTH-1 of both operands before comparing the MSB chunk. This makes the unsigned chunk order equal the signed order.
REQ-017 Early exit: the first chunk that differs SHALL decide the result (GT or LT) at that edge. If all N chunks are equal, the result SHALL be EQ at edge EN.
REQ-018 At the decision edge, SHALL load S with the full consistent flag set, set busy=0, and set done=1 for exactly the next cycle.
REQ-019 Latency SHALL be k cycles from E0, where k is the 1-based position (from the MSB) of the first differing chunk, or N if all chunks are equal.
REQ-020 S SHALL hold its value between completions, regardless of A, B or signed_mode changes.
REQ-021 A start while busy=1 SHALL be ignored; no queueing, and the latched operands are unchanged.
REQ-022 A start in the cycle where done=1 SHALL be accepted (busy is 0 then). done falls as normal, and S keeps the old result until the new decision.
REQ-023 A and B changing after E0 SHALL NOT affect the result in progress.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE, busy=0, done=0, S=6'b000000, and chunk index 0. It has priority over start.
REQ-025 reset during COMPARE SHALL abort the comparison with no done pulse. The first start after reset is deasserted SHALL behave as in REQ-014.

Structure
REQ-026 Package comparador_pkg SHALL hold the state encoding (IDLE, COMPARE) and the flag bit-index constants (FLAG_GT=5 ... FLAG_LT=0).
REQ-027 Sub-module comparador_chunk SHALL be a combinational CHUNK-bit unsigned compare with outputs gt, lt, eq. It is instantiated once.
REQ-028 Chunk index counter width SHALL be max(1, clog2(N)). Total RTL size is 120-400 lines.

Verification (WIDTH=16, CHUNK=4)
REQ-029 Unsigned, A=B=0x1234: done at E4, S=6'b011010.
REQ-030 Signed, A=0x8000, B=0x0001: done at E1, S=6'b010101. Unsigned with the same operands: done at E1, S=6'b100110.
REQ-031 Signed, A=0xFFFE, B=0xFFFF: done at E4, S=6'b010101.
REQ-032 Start at E0, reset=1 at E2: at E2 busy=0, done=0, S=0, and no done pulse afterwards. A start pulse during busy causes no extra done and does not change the result.
REQ-033 Back-to-back: second start asserted during the done cycle of the first compare: accepted, S retains the first result until the second done. Both results must be correct.
REQ-034 Random check: 10k random operand pairs in both modes, checked against a reference model (S and latency).
